// File: rtl/chan_link_pkg.sv
// Shared definitions for the multi-channel Aurora link monitor: the link state
// encoding, the per-channel register map and the status/counter bit layout.
package chan_link_pkg;

  // Link qualification states; the encoding is visible in the status register.
  typedef enum logic [1:0] {
    StDown = 2'd0,
    StQual = 2'd1,
    StUp   = 2'd2
  } link_state_e;

  // Per-channel register offsets (io_addr[3:0]).
  localparam logic [3:0] OffStatus   = 4'd0;
  localparam logic [3:0] OffFrameCnt = 4'd1;
  localparam logic [3:0] OffHardCnt  = 4'd2;
  localparam logic [3:0] OffSoftCnt  = 4'd3;
  localparam logic [3:0] OffDropCnt  = 4'd4;
  localparam logic [3:0] OffLoopback = 4'd5;
  localparam logic [3:0] OffCtrl     = 4'd6;

  // Bit positions of the raw/synced status vector, also status register [10:3].
  localparam int unsigned BitFrame   = 0;
  localparam int unsigned BitHard    = 1;
  localparam int unsigned BitSoft    = 2;
  localparam int unsigned BitChanUp  = 3;
  localparam int unsigned BitLaneUp  = 4;
  localparam int unsigned BitTxDone  = 5;
  localparam int unsigned BitRxDone  = 6;
  localparam int unsigned BitPllLost = 7;
  localparam int unsigned NumStatus  = 8;

  // Index of each counter within a lane's counter bundle.
  localparam int unsigned CntFrame = 0;
  localparam int unsigned CntHard  = 1;
  localparam int unsigned CntSoft  = 2;
  localparam int unsigned CntDrop  = 3;
  localparam int unsigned NumCnt   = 4;

  // Control register bits.
  localparam int unsigned CtrlClrCnt  = 0;
  localparam int unsigned CtrlClrLost = 1;

endpackage

// File: rtl/chan_link_lane_mon.sv
// Per-channel link supervisor: status synchroniser, error edge detection,
// link qualification FSM, saturating counters, sticky lost bit and loopback.
module chan_link_lane_mon
  import chan_link_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NumStatus-1:0]               status_raw,
  input  logic                               wr_loopback,
  input  logic                               wr_ctrl,
  input  logic [2:0]                         wr_data,
  output link_state_e                        state,
  output logic                               lost,
  output logic [NumStatus-1:0]               status_sync,
  output logic [NumCnt-1:0][CNT_WIDTH-1:0]   cnt,
  output logic [2:0]                         loopback,
  output logic                               link_ok
);

  localparam int unsigned StabW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0][NumStatus-1:0] sync_q;
  logic [2:0]                            err_prev_q;
  logic [2:0]                            err_rise;
  link_state_e                           state_q, state_d;
  logic [StabW-1:0]                      stab_q, stab_d;
  logic                                  drop;
  logic [NumCnt-1:0]                     cnt_inc;
  logic [NumCnt-1:0][CNT_WIDTH-1:0]      cnt_q;
  logic                                  lost_q;
  logic [2:0]                            loopback_q;
  logic                                  clr_cnt;
  logic                                  clr_lost;

  assign status_sync = sync_q[SYNC_STAGES-1];
  assign err_rise    = status_sync[2:0] & ~err_prev_q;
  assign clr_cnt     = wr_ctrl & wr_data[CtrlClrCnt];
  assign clr_lost    = wr_ctrl & wr_data[CtrlClrLost];

  // Synchroniser chain plus previous-value register for the three error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      err_prev_q <= '0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], status_raw};
      err_prev_q <= status_sync[2:0];
    end
  end

  // Link FSM state and stability counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDown;
      stab_q  <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
    end
  end

  // Link FSM next state; a PLL unlock overrides everything and only counts as
  // a drop when the link had already been qualified.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    drop    = 1'b0;
    if (status_sync[BitPllLost]) begin
      state_d = StDown;
      drop    = (state_q == StUp);
    end else begin
      case (state_q)
        StDown: begin
          if (status_sync[BitChanUp]) begin
            state_d = StQual;
            stab_d  = '0;
          end
        end
        StQual: begin
          if (!status_sync[BitChanUp]) begin
            state_d = StDown;
          end else if (stab_q == StabLast) begin
            state_d = StUp;
          end else begin
            stab_d = stab_q + StabW'(1);
          end
        end
        StUp: begin
          if (!status_sync[BitChanUp]) begin
            state_d = StDown;
            drop    = 1'b1;
          end
        end
        default: state_d = StDown;
      endcase
    end
  end

  assign cnt_inc[CntFrame] = err_rise[BitFrame];
  assign cnt_inc[CntHard]  = err_rise[BitHard];
  assign cnt_inc[CntSoft]  = err_rise[BitSoft];
  assign cnt_inc[CntDrop]  = drop;

  // Saturating counters; a software clear beats a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int k = 0; k < NumCnt; k++) begin
        if (clr_cnt) begin
          cnt_q[k] <= '0;
        end else if (cnt_inc[k] && (cnt_q[k] != CntMax)) begin
          cnt_q[k] <= cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // Sticky lost bit; a new drop beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lost_q <= 1'b0;
    end else if (drop) begin
      lost_q <= 1'b1;
    end else if (clr_lost) begin
      lost_q <= 1'b0;
    end
  end

  // Loopback control register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loopback_q <= '0;
    end else if (wr_loopback) begin
      loopback_q <= wr_data;
    end
  end

  assign state    = state_q;
  assign lost     = lost_q;
  assign cnt      = cnt_q;
  assign loopback = loopback_q;
  assign link_ok  = (state_q == StUp);

endmodule

// File: rtl/chan_link_monitor.sv
// Register-mapped supervisor for NUM_CHAN Aurora links: address decode, write
// steering to the per-channel lanes and a registered read mux.
module chan_link_monitor
  import chan_link_pkg::*;
#(
  parameter int unsigned NUM_CHAN      = 4,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 1024
) (
  input  logic                  io_clk,
  input  logic                  io_reset,
  input  logic                  io_sel,
  input  logic                  io_sync,
  input  logic [19:0]           io_addr,
  input  logic                  io_rd_en,
  input  logic                  io_wr_en,
  input  logic [31:0]           io_wr_data,
  output logic [31:0]           io_rd_data,
  output logic                  io_rd_ack,
  input  logic [NUM_CHAN-1:0]   frame_err,
  input  logic [NUM_CHAN-1:0]   hard_err,
  input  logic [NUM_CHAN-1:0]   soft_err,
  input  logic [NUM_CHAN-1:0]   channel_up,
  input  logic [NUM_CHAN-1:0]   lane_up,
  input  logic [NUM_CHAN-1:0]   tx_resetdone,
  input  logic [NUM_CHAN-1:0]   rx_resetdone,
  input  logic [NUM_CHAN-1:0]   pll_not_locked,
  output logic [3*NUM_CHAN-1:0] loopback_set,
  output logic [NUM_CHAN-1:0]   link_ok,
  output logic                  link_lost
);

  logic [3:0]  chan;
  logic [3:0]  off;
  logic        wr_fire;
  logic        rd_fire;
  logic [31:0] rd_word;
  logic [31:0] rd_data_q;
  logic        rd_ack_q;
  logic        unused_bits;

  logic [NUM_CHAN-1:0]                   wr_loopback;
  logic [NUM_CHAN-1:0]                   wr_ctrl;
  logic [NUM_CHAN-1:0]                   lane_lost;
  link_state_e                           lane_state [NUM_CHAN];
  logic [NumStatus-1:0]                  lane_sync  [NUM_CHAN];
  logic [NumCnt-1:0][CNT_WIDTH-1:0]      lane_cnt   [NUM_CHAN];
  logic [2:0]                            lane_lb    [NUM_CHAN];

  assign chan        = io_addr[7:4];
  assign off         = io_addr[3:0];
  assign wr_fire     = io_sel & io_sync & io_wr_en;
  assign rd_fire     = io_sel & io_sync & io_rd_en;
  assign unused_bits = ^{io_addr[19:8], io_wr_data[31:3]};

  // Steer writes to the addressed lane; out-of-range channels match nothing.
  always_comb begin
    wr_loopback = '0;
    wr_ctrl     = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      wr_loopback[i] = wr_fire && (chan == 4'(i)) && (off == OffLoopback);
      wr_ctrl[i]     = wr_fire && (chan == 4'(i)) && (off == OffCtrl);
    end
  end

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_lane
    chan_link_lane_mon #(
      .CNT_WIDTH    (CNT_WIDTH),
      .SYNC_STAGES  (SYNC_STAGES),
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_lane (
      .clk        (io_clk),
      .rst        (io_reset),
      .status_raw ({pll_not_locked[g], rx_resetdone[g], tx_resetdone[g], lane_up[g],
                    channel_up[g], soft_err[g], hard_err[g], frame_err[g]}),
      .wr_loopback(wr_loopback[g]),
      .wr_ctrl    (wr_ctrl[g]),
      .wr_data    (io_wr_data[2:0]),
      .state      (lane_state[g]),
      .lost       (lane_lost[g]),
      .status_sync(lane_sync[g]),
      .cnt        (lane_cnt[g]),
      .loopback   (lane_lb[g]),
      .link_ok    (link_ok[g])
    );
    assign loopback_set[3*g +: 3] = lane_lb[g];
  end

  assign link_lost = |lane_lost;

  // Read mux; unmapped offsets, the control register and absent channels read 0.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      if (chan == 4'(i)) begin
        case (off)
          OffStatus:   rd_word = {21'd0, lane_sync[i], lane_lost[i], lane_state[i]};
          OffFrameCnt: rd_word = 32'(lane_cnt[i][CntFrame]);
          OffHardCnt:  rd_word = 32'(lane_cnt[i][CntHard]);
          OffSoftCnt:  rd_word = 32'(lane_cnt[i][CntSoft]);
          OffDropCnt:  rd_word = 32'(lane_cnt[i][CntDrop]);
          OffLoopback: rd_word = {29'd0, lane_lb[i]};
          default:     rd_word = '0;
        endcase
      end
    end
  end

  // Registered read response: data is only non-zero during the ack cycle.
  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      rd_ack_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_ack_q  <= rd_fire;
      rd_data_q <= rd_fire ? rd_word : '0;
    end
  end

  assign io_rd_ack  = rd_ack_q;
  assign io_rd_data = rd_data_q;

endmodule

// File: tb/tb_chan_link_monitor.sv
// Self-checking bench for chan_link_monitor: directed link scenarios followed by
// randomized error pulses checked against a saturating-count reference model.
module tb_chan_link_monitor;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned SS = 2;
  localparam int unsigned SC = 16;
  localparam int          CntSat = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          io_sel, io_sync, io_rd_en, io_wr_en;
  logic [19:0]   io_addr;
  logic [31:0]   io_wr_data;
  logic [31:0]   io_rd_data;
  logic          io_rd_ack;
  logic [NC-1:0] frame_err, hard_err, soft_err, chan_up, lane_up, tx_done, rx_done, pll;
  logic [3*NC-1:0] loopback_set;
  logic [NC-1:0] link_ok;
  logic          link_lost;

  int n_tests = 0;
  int n_fail  = 0;

  chan_link_monitor #(
    .NUM_CHAN     (NC),
    .CNT_WIDTH    (CW),
    .SYNC_STAGES  (SS),
    .STABLE_CYCLES(SC)
  ) dut (
    .io_clk        (clk),
    .io_reset      (rst),
    .io_sel        (io_sel),
    .io_sync       (io_sync),
    .io_addr       (io_addr),
    .io_rd_en      (io_rd_en),
    .io_wr_en      (io_wr_en),
    .io_wr_data    (io_wr_data),
    .io_rd_data    (io_rd_data),
    .io_rd_ack     (io_rd_ack),
    .frame_err     (frame_err),
    .hard_err      (hard_err),
    .soft_err      (soft_err),
    .channel_up    (chan_up),
    .lane_up       (lane_up),
    .tx_resetdone  (tx_done),
    .rx_resetdone  (rx_done),
    .pll_not_locked(pll),
    .loopback_set  (loopback_set),
    .link_ok       (link_ok),
    .link_lost     (link_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges and land 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic io_write(input int ch, input int off, input logic [31:0] data);
    io_addr = {12'd0, 4'(ch), 4'(off)};
    io_wr_data = data;
    io_sel = 1'b1; io_sync = 1'b1; io_wr_en = 1'b1;
    tick(1);
    io_sel = 1'b0; io_sync = 1'b0; io_wr_en = 1'b0;
  endtask

  task automatic io_read(input int ch, input int off, output logic [31:0] data,
                         output logic ack);
    io_addr = {12'd0, 4'(ch), 4'(off)};
    io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1;
    tick(1);
    io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0;
    data = io_rd_data;
    ack  = io_rd_ack;
  endtask

  task automatic read_check(input string tag, input int ch, input int off,
                            input logic [31:0] exp);
    logic [31:0] d;
    logic        a;
    io_read(ch, off, d, a);
    check(tag, d, exp);
    check({tag, "_ack"}, {31'd0, a}, 32'd1);
  endtask

  // Expected status word built from the currently driven (settled) inputs.
  function automatic logic [31:0] exp_status(input int st, input logic lost, input int ch);
    logic [7:0] s;
    s = {pll[ch], rx_done[ch], tx_done[ch], lane_up[ch], chan_up[ch], soft_err[ch],
         hard_err[ch], frame_err[ch]};
    return {21'd0, s, lost, 2'(st)};
  endfunction

  int              exp_cnt [NC][3];
  logic [2:0]      lb_model [NC];
  logic [3*NC-1:0] exp_lb;
  logic [31:0]     rd_d;
  logic            rd_a;

  initial begin
    rst = 1'b1;
    io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0; io_wr_en = 1'b0;
    io_addr = '0; io_wr_data = '0;
    frame_err = '0; hard_err = '0; soft_err = '0; chan_up = '0;
    lane_up = '0; tx_done = '0; rx_done = '0; pll = '0;
    tick(3);
    check("rst_link_ok", {28'd0, link_ok}, 32'd0);
    check("rst_link_lost", {31'd0, link_lost}, 32'd0);
    check("rst_loopback", {20'd0, loopback_set}, 32'd0);
    check("rst_rd_ack", {31'd0, io_rd_ack}, 32'd0);
    check("rst_rd_data", io_rd_data, 32'd0);
    rst = 1'b0;
    tick(1);

    for (int off = 0; off < 16; off++) read_check($sformatf("ch0_off%0d", off), 0, off, 0);
    io_read(0, 0, rd_d, rd_a);
    tick(1);
    check("rd_ack_one_cycle", {31'd0, io_rd_ack}, 32'd0);
    check("rd_data_back_to_0", io_rd_data, 32'd0);

    // Qualification timing on channel 1.
    chan_up[1] = 1'b1;
    tick(SS + SC);
    check("ch1_link_ok_early", {31'd0, link_ok[1]}, 32'd0);
    tick(1);
    check("ch1_link_ok_rise", {31'd0, link_ok[1]}, 32'd1);
    read_check("ch1_status_up", 1, 0, exp_status(2, 1'b0, 1));

    // Loss of link after UP.
    chan_up[1] = 1'b0;
    tick(SS);
    check("ch1_link_ok_hold", {31'd0, link_ok[1]}, 32'd1);
    tick(1);
    check("ch1_link_ok_fall", {31'd0, link_ok[1]}, 32'd0);
    check("link_lost_set", {31'd0, link_lost}, 32'd1);
    read_check("ch1_drop_cnt", 1, 4, 1);
    read_check("ch1_status_lost", 1, 0, exp_status(0, 1'b1, 1));
    io_write(1, 6, 32'd2);
    check("link_lost_clr", {31'd0, link_lost}, 32'd0);
    read_check("ch1_status_clr", 1, 0, exp_status(0, 1'b0, 1));
    read_check("ch1_drop_kept", 1, 4, 1);

    // Frame error saturation, then clear racing a soft error edge.
    repeat (5) begin
      frame_err[2] = 1'b1; tick(1);
      frame_err[2] = 1'b0; tick(2);
    end
    tick(SS + 2);
    read_check("ch2_frame_sat", 2, 1, CntSat);
    soft_err[2] = 1'b1;
    tick(SS);
    io_write(2, 6, 32'd1);
    soft_err[2] = 1'b0;
    tick(SS + 2);
    read_check("ch2_soft_clr_wins", 2, 3, 0);
    read_check("ch2_frame_clr", 2, 1, 0);

    // Loopback register and out-of-range channel.
    io_write(3, 5, 32'hFFFF_FFFA);
    check("ch3_lb_pins", {29'd0, loopback_set[11:9]}, 32'd2);
    read_check("ch3_lb_read", 3, 5, 2);
    io_write(5, 5, 32'd7);
    io_write(5, 6, 32'd3);
    check("ch5_lb_ignored", {20'd0, loopback_set}, 32'h400);
    read_check("ch5_lb_read", 5, 5, 0);
    read_check("ch5_status_read", 5, 0, 0);

    // channel_up glitch during qualification on channel 0.
    chan_up[0] = 1'b1;
    tick(SS + 4);
    read_check("ch0_status_qual", 0, 0, exp_status(1, 1'b0, 0));
    chan_up[0] = 1'b0;
    tick(SS + 1);
    chan_up[0] = 1'b1;
    read_check("ch0_status_glitch_down", 0, 0, 0);
    tick(SS + SC - 1);
    check("ch0_requal_early", {31'd0, link_ok[0]}, 32'd0);
    tick(1);
    check("ch0_requal_up", {31'd0, link_ok[0]}, 32'd1);
    read_check("ch0_glitch_no_drop", 0, 4, 0);

    // PLL unlock while UP counts as a drop.
    pll[0] = 1'b1;
    tick(SS);
    check("ch0_pll_hold", {31'd0, link_ok[0]}, 32'd1);
    tick(1);
    check("ch0_pll_down", {31'd0, link_ok[0]}, 32'd0);
    chan_up[0] = 1'b0;
    tick(2);
    read_check("ch0_pll_drop", 0, 4, 1);
    check("pll_link_lost", {31'd0, link_lost}, 32'd1);
    pll[0] = 1'b0;
    tick(SS + 2);

    // Randomized error pulses against a saturating count model.
    for (int ch = 0; ch < NC; ch++) begin
      io_write(ch, 6, 32'd3);
      for (int t = 0; t < 3; t++) exp_cnt[ch][t] = 0;
      lb_model[ch] = (ch == 3) ? 3'd2 : 3'd0;
    end
    check("rand_lost_cleared", {31'd0, link_lost}, 32'd0);
    repeat (4) begin
      lane_up = NC'($urandom);
      tx_done = NC'($urandom);
      rx_done = NC'($urandom);
      for (int ch = 0; ch < NC; ch++) begin
        for (int t = 0; t < 3; t++) begin
          int n;
          n = $urandom_range(0, 4);
          repeat (n) begin
            case (t)
              0: frame_err[ch] = 1'b1;
              1: hard_err[ch] = 1'b1;
              default: soft_err[ch] = 1'b1;
            endcase
            tick($urandom_range(1, 3));
            frame_err[ch] = 1'b0; hard_err[ch] = 1'b0; soft_err[ch] = 1'b0;
            tick($urandom_range(1, 3));
          end
          exp_cnt[ch][t] = (exp_cnt[ch][t] + n > CntSat) ? CntSat : exp_cnt[ch][t] + n;
        end
      end
      tick(SS + 2);
      for (int ch = 0; ch < NC; ch++) begin
        logic [31:0] lb_word;
        read_check($sformatf("rnd_ch%0d_frame", ch), ch, 1, exp_cnt[ch][0]);
        read_check($sformatf("rnd_ch%0d_hard", ch), ch, 2, exp_cnt[ch][1]);
        read_check($sformatf("rnd_ch%0d_soft", ch), ch, 3, exp_cnt[ch][2]);
        read_check($sformatf("rnd_ch%0d_status", ch), ch, 0, exp_status(0, 1'b0, ch));
        read_check($sformatf("rnd_ch%0d_off_hi", ch), ch, $urandom_range(7, 15), 0);
        if ($urandom_range(0, 2) == 0) begin
          io_write(ch, 6, 32'd1);
          for (int t = 0; t < 3; t++) exp_cnt[ch][t] = 0;
        end
        lb_word = $urandom;
        io_write(ch, 5, lb_word);
        lb_model[ch] = lb_word[2:0];
        read_check($sformatf("rnd_ch%0d_lb", ch), ch, 5, {29'd0, lb_model[ch]});
      end
      for (int ch = 0; ch < NC; ch++) exp_lb[3*ch +: 3] = lb_model[ch];
      check("rnd_loopback_set", {20'd0, loopback_set}, {20'd0, exp_lb});
    end

    // Reset in the middle of a read: no ack, everything cleared.
    chan_up[3] = 1'b1;
    tick(SS + SC + 2);
    check("ch3_up_before_rst", {31'd0, link_ok[3]}, 32'd1);
    io_addr = {12'd0, 4'd3, 4'd5};
    io_sel = 1'b1; io_sync = 1'b1; io_rd_en = 1'b1;
    #2 rst = 1'b1;
    tick(1);
    io_sel = 1'b0; io_sync = 1'b0; io_rd_en = 1'b0;
    check("midrst_rd_ack", {31'd0, io_rd_ack}, 32'd0);
    check("midrst_rd_data", io_rd_data, 32'd0);
    check("midrst_link_ok", {28'd0, link_ok}, 32'd0);
    check("midrst_loopback", {20'd0, loopback_set}, 32'd0);
    rst = 1'b0;
    chan_up = '0;
    tick(2);
    read_check("postrst_ch2_frame", 2, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
